// File: rtl/bitstream_field_reader_if.sv
// Handshake bundle for the bitstream field reader: byte input, field requests,
// field output and the fill level.
interface bitstream_field_reader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       req_valid;
    logic [3:0] req_len;
    logic       req_ready;
    logic       align;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] bits_avail;

    modport slave (
        input  in_data, in_valid, req_valid, req_len, align, out_ready,
        output in_ready, req_ready, out_data, out_valid, bits_avail
    );

    modport master (
        output in_data, in_valid, req_valid, req_len, align, out_ready,
        input  in_ready, req_ready, out_data, out_valid, bits_avail
    );
endinterface

// File: rtl/bitstream_field_reader.sv
// Two-byte window over an incoming byte stream that serves LSB-first fields of
// 1..8 bits through a 16-bit right funnel shifter.
module funnel_shifter (
    input  logic [15:0] i,
    input  logic [3:0]  n,
    output logic [7:0]  o
);
    logic [15:0] shifted;

    assign shifted = i >> n;
    assign o       = shifted[7:0];
endmodule

module bitstream_field_reader (
    input  logic                     clk,
    input  logic                     rst,
    bitstream_field_reader_if.slave  bus
);
    logic [7:0]  lo_reg, lo_next;
    logic [7:0]  hi_reg, hi_next;
    logic        lo_v_reg, lo_v_next;
    logic        hi_v_reg, hi_v_next;
    logic [2:0]  ptr_reg, ptr_next;
    logic [7:0]  out_data_reg, out_data_next;
    logic        out_valid_reg, out_valid_next;

    logic [15:0] window;
    logic [7:0]  field;
    logic [3:0]  eff_len;
    logic [7:0]  field_mask;
    logic [3:0]  bit_sum;
    logic        both_valid;
    logic        in_ready;
    logic        req_ready;
    logic        in_fire;
    logic        req_fire;
    logic [4:0]  byte_bits;

    assign window = {hi_reg, lo_reg};

    funnel_shifter u_shift (
        .i (window),
        .n ({1'b0, ptr_reg}),
        .o (field)
    );

    // Lengths above 8 clamp to a full byte; 0 yields an empty field.
    assign eff_len = (bus.req_len > 4'd8) ? 4'd8 : bus.req_len;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign field_mask[gi] = (eff_len > 4'(gi));
        end
    endgenerate

    assign bit_sum    = {1'b0, ptr_reg} + eff_len;
    assign both_valid = lo_v_reg && hi_v_reg;

    // A consume needs both bytes, which also blocks byte input that cycle.
    assign in_ready  = !both_valid && !bus.align;
    assign req_ready = both_valid && !bus.align && (!out_valid_reg || bus.out_ready);
    assign in_fire   = bus.in_valid && in_ready;
    assign req_fire  = bus.req_valid && req_ready;

    assign byte_bits = {1'b0, lo_v_reg && hi_v_reg, lo_v_reg ^ hi_v_reg, 2'b00} << 1;

    assign bus.in_ready   = in_ready;
    assign bus.req_ready  = req_ready;
    assign bus.out_data   = out_data_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.bits_avail = byte_bits - {2'b00, ptr_reg};

    always_comb begin
        lo_next        = lo_reg;
        hi_next        = hi_reg;
        lo_v_next      = lo_v_reg;
        hi_v_next      = hi_v_reg;
        ptr_next       = ptr_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;

        if (in_fire) begin
            if (!lo_v_reg) begin
                lo_next   = bus.in_data;
                lo_v_next = 1'b1;
            end else begin
                hi_next   = bus.in_data;
                hi_v_next = 1'b1;
            end
        end

        if (req_fire) begin
            out_data_next  = field & field_mask;
            out_valid_next = 1'b1;
            ptr_next       = bit_sum[2:0];
            if (bit_sum[3]) begin
                lo_next   = hi_reg;
                hi_v_next = 1'b0;
            end
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end

        // Align drops the partly read low byte; a fresh byte boundary is a no-op.
        if (bus.align && lo_v_reg && (ptr_reg != 3'd0)) begin
            lo_next   = hi_reg;
            lo_v_next = hi_v_reg;
            hi_v_next = 1'b0;
            ptr_next  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_reg        <= 8'h00;
            hi_reg        <= 8'h00;
            lo_v_reg      <= 1'b0;
            hi_v_reg      <= 1'b0;
            ptr_reg       <= 3'd0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
        end else begin
            lo_reg        <= lo_next;
            hi_reg        <= hi_next;
            lo_v_reg      <= lo_v_next;
            hi_v_reg      <= hi_v_next;
            ptr_reg       <= ptr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end
endmodule

// File: tb/tb_bitstream_field_reader.sv
// Scoreboard bench for bitstream_field_reader: a bit-queue reference model
// predicts readiness, fill level and every emitted field.
module tb_bitstream_field_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bitstream_field_reader_if bus ();

    bitstream_field_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb[$];
    bit         bq[$];
    bit         ov_m = 1'b0;

    int         sz_m;
    int         len_m;
    int         drop_m;
    bit         ir_m;
    bit         rr_m;
    logic [7:0] f_m;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: stream held as a queue of bits, oldest first.
    always @(negedge clk) begin
        if (rst) begin
            bq.delete();
            sb.delete();
            ov_m = 1'b0;
        end else begin
            sz_m = bq.size();
            ir_m = (sz_m <= 8) && !bus.align;
            rr_m = (sz_m > 8) && !bus.align && (!ov_m || bus.out_ready);
            check("in_ready", bus.in_ready, ir_m);
            check("req_ready", bus.req_ready, rr_m);
            check("bits_avail", bus.bits_avail, sz_m);
            check("out_valid", bus.out_valid, ov_m);
            if (ov_m) begin
                check("sb_level", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("out_data", bus.out_data, sb[0]);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            if (bus.in_valid && ir_m) begin
                for (int k = 0; k < 8; k++) bq.push_back(bus.in_data[k]);
            end
            if (bus.req_valid && rr_m) begin
                len_m = (bus.req_len > 4'd8) ? 8 : int'(bus.req_len);
                f_m = 8'h00;
                for (int k = 0; k < len_m; k++) f_m[k] = bq.pop_front();
                sb.push_back(f_m);
            end
            if (bus.align && sz_m > 0) begin
                drop_m = sz_m % 8;
                for (int k = 0; k < drop_m; k++) void'(bq.pop_front());
            end
            ov_m = (bus.req_valid && rr_m) ? 1'b1 : (bus.out_ready ? 1'b0 : ov_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.in_valid  = 1'b0;
        bus.req_valid = 1'b0;
        bus.align     = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.in_ready) begin
                tick();
                bus.in_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("in_timeout", bus.in_ready, 1);
    endtask

    task automatic request(input logic [3:0] len);
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.req_ready) begin
                tick();
                bus.req_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        check("req_timeout", bus.req_ready, 1);
    endtask

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_len   = 4'd0;
        bus.align     = 1'b0;
        bus.out_ready = 1'b1;

        reset_dut();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_avail", bus.bits_avail, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Basic extraction across a byte boundary
        send_byte(8'hA5);
        send_byte(8'h3C);
        request(4'd4);
        check("t1_f0", bus.out_data, 8'h05);
        check("t1_avail12", bus.bits_avail, 12);
        request(4'd8);
        check("t1_f1", bus.out_data, 8'hCA);
        check("t1_avail4", bus.bits_avail, 4);
        check("t1_in_ready", bus.in_ready, 1);

        // Backpressure holds the field; release gives a gapless next field
        reset_dut();
        send_byte(8'h5A);
        send_byte(8'hC3);
        bus.out_ready = 1'b0;
        request(4'd4);
        bus.req_len   = 4'd4;
        bus.req_valid = 1'b1;
        repeat (5) begin
            check("t2_hold_rr", bus.req_ready, 0);
            check("t2_hold_data", bus.out_data, 8'h0A);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("t2_rr", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("t2_nogap", bus.out_valid, 1);
        check("t2_f1", bus.out_data, 8'h05);
        tick();
        check("t2_drain", bus.out_valid, 0);

        // Length edges on an all-ones window
        reset_dut();
        send_byte(8'hFF);
        send_byte(8'hFF);
        request(4'd0);
        check("t3_len0", bus.out_data, 8'h00);
        check("t3_len0_avail", bus.bits_avail, 16);
        request(4'd12);
        check("t3_len12", bus.out_data, 8'hFF);
        check("t3_len12_avail", bus.bits_avail, 8);
        send_byte(8'hFF);
        request(4'd7);
        check("t3_len7", bus.out_data, 8'h7F);
        request(4'd8);
        check("t3_s15", bus.out_data, 8'hFF);
        check("t3_s15_avail", bus.bits_avail, 1);

        // Align drops the rest of the low byte, and is idempotent at ptr 0
        reset_dut();
        send_byte(8'h12);
        send_byte(8'h34);
        request(4'd3);
        check("t4_avail13", bus.bits_avail, 13);
        bus.align = 1'b1;
        #1;
        check("t4_align_rr", bus.req_ready, 0);
        tick();
        bus.align = 1'b0;
        check("t4_avail8", bus.bits_avail, 8);
        bus.align = 1'b1;
        tick();
        bus.align = 1'b0;
        check("t4_again", bus.bits_avail, 8);
        send_byte(8'h56);
        request(4'd8);
        check("t4_old_hi", bus.out_data, 8'h34);

        // Starvation: request waits until a second byte is buffered
        reset_dut();
        send_byte(8'h81);
        bus.req_len   = 4'd1;
        bus.req_valid = 1'b1;
        repeat (3) begin
            check("t5_starve", bus.req_ready, 0);
            tick();
        end
        send_byte(8'h00);
        check("t5_rr", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("t5_ov", bus.out_valid, 1);
        check("t5_out", bus.out_data, 8'h01);

        // Reset while a field is pending and bytes are buffered
        reset_dut();
        send_byte(8'h11);
        send_byte(8'h22);
        bus.out_ready = 1'b0;
        request(4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("t6_ov", bus.out_valid, 0);
        check("t6_avail", bus.bits_avail, 0);
        check("t6_in_ready", bus.in_ready, 1);

        // Random traffic checked entirely by the scoreboard
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_data   = 8'($urandom);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_len   = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.align     = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.req_valid = 1'b0;
        bus.align     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("final_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
